// File: rtl/sat_round_pipe.sv
// Two-stage signed width reducer: shift (optionally round), saturate, then report clips.
// Define SAT_ROUND_PIPE_ROUNDING_EN to build the round-half-up adder; otherwise always truncate.
module sat_round_pipe #(
    parameter int unsigned IW = 22,
    parameter int unsigned OW = 16,
    parameter int unsigned SH = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [IW-1:0] sig_in,
    input  logic          round_en,
    input  logic          clr_flags,
    output logic          out_valid,
    output logic [OW-1:0] sig_out,
    output logic          sat_hi,
    output logic          sat_lo,
    output logic          sat_sticky,
    output logic [CW-1:0] sat_count
);

    // One guard bit above the shifted sample so the rounding increment cannot wrap.
    localparam int unsigned QW = IW - SH + 1;

    logic [QW-1:0] w_shift;
    logic [QW-1:0] w_q1;
    logic          w_unused;

    assign w_shift  = {sig_in[IW-1], sig_in[IW-1:SH]};
    assign w_unused = ^{round_en, sig_in};

`ifdef SAT_ROUND_PIPE_ROUNDING_EN
    logic w_rbit;

    generate
        if (SH > 0) begin : g_rbit
            assign w_rbit = sig_in[SH-1];
        end else begin : g_no_rbit
            assign w_rbit = 1'b0;
        end
    endgenerate

    assign w_q1 = w_shift + {{(QW-1){1'b0}}, round_en & w_rbit};
`else
    assign w_q1 = w_shift;
`endif

    logic          r_v1;
    logic [QW-1:0] r_q1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_q1 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_q1 <= w_q1;
            end
        end
    end

    // Overflow when the bits from OW-1 upward are not a pure sign extension.
    logic          w_sign;
    logic          w_ovf;
    logic          w_hi;
    logic          w_lo;
    logic [OW-1:0] w_sat;

    assign w_sign = r_q1[QW-1];
    assign w_ovf  = (r_q1[QW-1:OW-1] != {(QW-OW+1){w_sign}});
    assign w_hi   = w_ovf & ~w_sign;
    assign w_lo   = w_ovf & w_sign;

    always_comb begin
        w_sat = r_q1[OW-1:0];
        if (w_hi) begin
            w_sat = {1'b0, {(OW-1){1'b1}}};
        end else if (w_lo) begin
            w_sat = {1'b1, {(OW-1){1'b0}}};
        end
    end

    logic          r_v2;
    logic [OW-1:0] r_out;
    logic          r_hi;
    logic          r_lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v2  <= 1'b0;
            r_out <= '0;
            r_hi  <= 1'b0;
            r_lo  <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            r_hi <= r_v1 & w_hi;
            r_lo <= r_v1 & w_lo;
            if (r_v1) begin
                r_out <= w_sat;
            end
        end
    end

    logic          w_clip;
    logic          r_sticky;
    logic [CW-1:0] r_count;

    assign w_clip = r_v2 & (r_hi | r_lo);

    // Clear wins first, then a coincident clip is counted on top of it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (clr_flags) begin
            r_sticky <= w_clip;
            r_count  <= {{(CW-1){1'b0}}, w_clip};
        end else if (w_clip) begin
            r_sticky <= 1'b1;
            if (r_count != {CW{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign out_valid  = r_v2;
    assign sig_out    = r_out;
    assign sat_hi     = r_hi;
    assign sat_lo     = r_lo;
    assign sat_sticky = r_sticky;
    assign sat_count  = r_count;

endmodule
